// File: rtl/alu_pkg.sv
// Shared op codes, M-extension funct3 encoding, FSM states and special divide results
// for the alu_mdu execute unit.
package alu_pkg;
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_PASS = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_BEQ  = 4'b1000;
   localparam logic [3:0] ALU_BNE  = 4'b1001;
   localparam logic [3:0] ALU_SUB  = 4'b1010;
   localparam logic [3:0] ALU_DIFF = 4'b1011;
   localparam logic [3:0] ALU_SLT  = 4'b1100;
   localparam logic [3:0] ALU_BGE  = 4'b1101;
   localparam logic [3:0] ALU_SLTU = 4'b1110;
   localparam logic [3:0] ALU_BGEU = 4'b1111;

   typedef enum logic [2:0] {
      F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU
   } m_funct_e;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

   // Sliced down to the datapath width at the point of use (W <= 64).
   localparam int SPEC_MAX_W = 64;
   localparam logic [SPEC_MAX_W-1:0] DIVZ_QUO = '1;
   localparam logic [SPEC_MAX_W-1:0] OVF_REM  = '0;
endpackage

// File: rtl/alu_mdu_div_iter.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, W cycles.
// The first step is taken on the start cycle straight from the operands.
module div_iter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] quo,
   output logic [W-1:0] rem
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  d_q, src_q, src_r, src_d, nxt_r;
   logic [W:0]    r_sh, trial;
   logic [CW-1:0] cnt;
   logic          run, take;

   always_comb begin
      src_q = start ? dividend : quo;
      src_r = start ? '0 : rem;
      src_d = start ? divisor : d_q;
      r_sh  = {src_r, src_q[W-1]};
      trial = r_sh - {1'b0, src_d};
      // No borrow means the shifted remainder covers the divisor.
      take  = !trial[W];
      nxt_r = take ? trial[W-1:0] : r_sh[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run  <= 1'b0;
         done <= 1'b0;
         cnt  <= '0;
         quo  <= '0;
         rem  <= '0;
         d_q  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            quo <= {src_q[W-2:0], take};
            rem <= nxt_r;
            d_q <= divisor;
            cnt <= CW'(1);
            run <= 1'b1;
         end else if (run) begin
            quo <= {src_q[W-2:0], take};
            rem <= nxt_r;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
               run  <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with RV32M multiply/divide: base ops return next cycle,
// MUL* after MUL_LAT cycles, DIV*/REM* after W+1 cycles, all behind valid/ready.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int W       = 32,
   parameter int MUL_LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         md_sel,
   input  logic [3:0]   ALUctrl,
   input  logic [W-1:0] N1,
   input  logic [W-1:0] N2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out,
   output logic         flag,
   output logic         busy
);
   localparam int SHW = $clog2(W);
   localparam logic [1:0] MUL_LAST = 2'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
   localparam int MUL_RD = MUL_LAT > 1 ? MUL_LAT - 2 : 0;

   state_e state, state_nxt;
   logic   accept;

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   // Base ALU
   logic [W:0]     sub_full;
   logic [W-1:0]   diff, alu_res;
   logic [SHW-1:0] sh;
   logic           c_flag, z_flag, s_flag, v_flag, lt, alu_flag;

   assign sub_full = {1'b0, N1} + {1'b0, ~N2} + {{W{1'b0}}, 1'b1};
   assign diff     = sub_full[W-1:0];
   assign c_flag   = sub_full[W];
   assign z_flag   = (diff == '0);
   assign s_flag   = diff[W-1];
   assign v_flag   = (N1[W-1] != N2[W-1]) && (diff[W-1] != N1[W-1]);
   assign lt       = s_flag ^ v_flag;
   assign sh       = N2[SHW-1:0];

   always_comb begin
      alu_res  = diff;
      alu_flag = 1'b1;
      case (ALUctrl)
         ALU_ADD:  alu_res = N1 + N2;
         ALU_PASS: alu_res = N2;
         ALU_AND:  alu_res = N1 & N2;
         ALU_OR:   alu_res = N1 | N2;
         ALU_XOR:  alu_res = N1 ^ N2;
         ALU_SLL:  alu_res = N1 << sh;
         ALU_SRL:  alu_res = N1 >> sh;
         ALU_SRA:  alu_res = $signed(N1) >>> sh;
         ALU_BEQ:  alu_flag = z_flag;
         ALU_BNE:  alu_flag = !z_flag;
         ALU_SUB:  alu_flag = 1'b0;
         ALU_DIFF: alu_flag = 1'b1;
         ALU_SLT:  begin alu_flag = lt;      alu_res = {{(W-1){1'b0}}, lt};      end
         ALU_BGE:  alu_flag = !lt;
         ALU_SLTU: begin alu_flag = !c_flag; alu_res = {{(W-1){1'b0}}, !c_flag}; end
         ALU_BGEU: alu_flag = c_flag;
         default:  ;
      endcase
   end

   // Multiplier: full 2W product, then a MUL_LAT-1 stage delay pipe
   m_funct_e     f3;
   logic [2*W-1:0] a_ext, b_ext, prod;
   logic [W-1:0] mul_res;
   logic [W-1:0] mul_pipe [MUL_LAT];
   logic [1:0]   mul_cnt;

   assign f3      = m_funct_e'(ALUctrl[2:0]);
   assign a_ext   = (f3 == F3_MULH || f3 == F3_MULHSU) ? {{W{N1[W-1]}}, N1} : {{W{1'b0}}, N1};
   assign b_ext   = (f3 == F3_MULH) ? {{W{N2[W-1]}}, N2} : {{W{1'b0}}, N2};
   assign prod    = a_ext * b_ext;
   assign mul_res = (f3 == F3_MUL) ? prod[W-1:0] : prod[2*W-1:W];

   always_ff @(posedge clk) begin
      mul_pipe[0] <= mul_res;
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
   end

   // Divider: sign handling and special cases around the unsigned iterator
   logic         div_signed, div_rem, div_zero, div_ovf, div_sp, div_start, div_done;
   logic         neg_q, neg_r, rem_sel;
   logic [W-1:0] a_mag, b_mag, spec_res, d_quo, d_rem, div_fix;

   assign div_signed = !ALUctrl[0];
   assign div_rem    = ALUctrl[1];
   assign div_zero   = (N2 == '0);
   assign div_ovf    = div_signed && (N1 == {1'b1, {(W-1){1'b0}}}) && (N2 == '1);
   assign div_sp     = div_zero || div_ovf;
   assign spec_res   = div_rem ? (div_zero ? N1 : OVF_REM[W-1:0])
                               : (div_zero ? DIVZ_QUO[W-1:0] : N1);
   assign a_mag      = (div_signed && N1[W-1]) ? -N1 : N1;
   assign b_mag      = (div_signed && N2[W-1]) ? -N2 : N2;
   assign div_start  = accept && md_sel && ALUctrl[2] && !div_sp;
   assign div_fix    = rem_sel ? (neg_r ? -d_rem : d_rem) : (neg_q ? -d_quo : d_quo);

   div_iter #(.W(W)) u_div (
      .clk(clk), .rst(rst), .start(div_start), .dividend(a_mag), .divisor(b_mag),
      .done(div_done), .quo(d_quo), .rem(d_rem)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && md_sel) begin
            if (!ALUctrl[2]) begin
               if (MUL_LAT > 1) state_nxt = MUL;
            end else if (!div_sp) state_nxt = DIV;
         end
         MUL:     if (mul_cnt == MUL_LAST) state_nxt = IDLE;
         DIV:     if (div_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         flag      <= 1'b0;
         mul_cnt   <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         rem_sel   <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         mul_cnt <= (state == MUL) ? mul_cnt + 2'd1 : 2'd0;
         if (accept) begin
            if (!md_sel) begin
               out <= alu_res; flag <= alu_flag; out_valid <= 1'b1;
            end else if (!ALUctrl[2]) begin
               if (MUL_LAT == 1) begin out <= mul_res; flag <= 1'b1; out_valid <= 1'b1; end
            end else if (div_sp) begin
               out <= spec_res; flag <= 1'b1; out_valid <= 1'b1;
            end else begin
               neg_q   <= div_signed && (N1[W-1] ^ N2[W-1]);
               neg_r   <= div_signed && N1[W-1];
               rem_sel <= div_rem;
            end
         end
         if (state == MUL && mul_cnt == MUL_LAST) begin
            out <= mul_pipe[MUL_RD]; flag <= 1'b1; out_valid <= 1'b1;
         end
         if (state == DIV && div_done) begin
            out <= div_fix; flag <= 1'b1; out_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: stimulus pushes expected results, a negedge
// monitor pops and compares on every output handshake.
module tb_alu_mdu;
   localparam int W = 32;

   logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, md_sel = 1'b0, out_ready = 1'b1;
   logic         in_ready, out_valid, flag, busy;
   logic [3:0]   ALUctrl = '0;
   logic [W-1:0] N1 = '0, N2 = '0, out;

   typedef struct {
      string        nm;
      logic [W-1:0] out;
      logic         flag;
      int           acc;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, errors = 0, cyc = 0, last_wait = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_mdu #(.W(W), .MUL_LAT(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .md_sel(md_sel),
      .ALUctrl(ALUctrl), .N1(N1), .N2(N2), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .flag(flag), .busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   exp_t m;
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: got out %h, required no output", out);
         end else begin
            m = sb.pop_front();
            chk({m.nm, "_out"}, out, m.out);
            chk({m.nm, "_flag"}, {31'b0, flag}, {31'b0, m.flag});
            if (m.lat != 0) chk({m.nm, "_latency"}, 32'(cyc - m.acc), 32'(m.lat));
         end
      end
   end

   task automatic issue(input string nm, input logic md, input logic [3:0] c,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eo, input logic ef, input int lat, input bit push);
      int   n = 0;
      exp_t e;
      md_sel = md; ALUctrl = c; N1 = a; N2 = b; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin n++; @(negedge clk); end
      last_wait = n;
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL %s_issue_timeout: in_ready still %b, required 1", nm, in_ready);
      end else if (push) begin
         e.nm = nm; e.out = eo; e.flag = ef; e.acc = cyc; e.lat = lat;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin n++; @(negedge clk); end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int w1, bad, seen;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out", out, 32'd0);
      chk("rst_flag", {31'b0, flag}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // base ops, back-to-back
      issue("add", 0, 4'b0000, 32'd5, 32'd7, 32'd12, 1, 1, 1); w1 = last_wait;
      issue("beq", 0, 4'b1000, 32'd3, 32'd3, 32'd0, 1, 1, 1);
      chk("b2b_ready_waits", 32'(w1 + last_wait), 32'd0);
      issue("slt",  0, 4'b1100, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 1, 1);
      issue("sltu", 0, 4'b1110, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 1, 1);
      issue("bge",  0, 4'b1101, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1, 1);
      issue("bne",  0, 4'b1001, 32'd3, 32'd4, 32'hFFFFFFFF, 1, 1, 1);
      issue("bgeu", 0, 4'b1111, 32'd1, 32'd2, 32'hFFFFFFFF, 0, 1, 1);
      issue("sub",  0, 4'b1010, 32'd10, 32'd3, 32'd7, 0, 1, 1);
      issue("sll",  0, 4'b0101, 32'd1, 32'h21, 32'd2, 1, 1, 1);
      issue("sra",  0, 4'b0111, 32'h80000000, 32'hFFFFFFE4, 32'hF8000000, 1, 1, 1);
      issue("xor",  0, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 1, 1);
      issue("pass", 0, 4'b0001, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 1);

      // multiplies
      issue("mulh",   1, 4'b0001, 32'h80000000, 32'h80000000, 32'h40000000, 1, 2, 1);
      issue("mulhu",  1, 4'b0011, 32'hFFFFFFFF, 32'd2, 32'd1, 1, 2, 1);
      issue("mul",    1, 4'b0000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1, 2, 1);
      issue("mulhsu", 1, 4'b0010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1, 2, 1);

      // iterative divide, inputs scrambled while busy
      issue("div", 1, 4'b0100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1, 33, 1);
      bad = 0;
      repeat (32) begin
         N1 = $urandom; N2 = $urandom;
         @(negedge clk);
         if (!busy || in_ready) bad++;
      end
      chk("div_busy_window", 32'(bad), 32'd0);
      issue("rem",  1, 4'b0110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1, 33, 1);
      issue("remu", 1, 4'b0111, 32'd100, 32'd7, 32'd2, 1, 33, 1);
      issue("divn", 1, 4'b0100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 33, 1);
      issue("divu0",  1, 4'b0101, 32'd1234, 32'd0, 32'hFFFFFFFF, 1, 1, 1);
      issue("rem0",   1, 4'b0110, 32'd1234, 32'd0, 32'd1234, 1, 1, 1);
      issue("divovf", 1, 4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, 1);
      issue("removf", 1, 4'b0110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1, 1);
      drain();

      // backpressure with a divide result pending
      out_ready = 1'b0;
      issue("div_bp", 1, 4'b0100, 32'd100, 32'd3, 32'd33, 1, 0, 1);
      bad = 0;
      while (!out_valid && bad < 60) begin bad++; @(negedge clk); end
      chk("bp_valid_seen", {31'b0, out_valid}, 32'd1);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (out !== 32'd33 || !out_valid || in_ready) bad++;
      end
      chk("bp_hold", 32'(bad), 32'd0);
      @(posedge clk); #1 out_ready = 1'b1;
      drain();

      // reset in the middle of a divide
      issue("div_rst", 1, 4'b0100, 32'd1000, 32'd3, 32'd0, 1, 0, 0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      seen = 0;
      repeat (40) begin @(negedge clk); if (out_valid) seen++; end
      chk("midrst_no_result", 32'(seen), 32'd0);
      @(posedge clk); #1;
      issue("add_after", 0, 4'b0000, 32'hFFFFFFFF, 32'd2, 32'd1, 1, 1, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle ALU.
- Executes the base integer/compare ops with a registered 1-cycle result.
- Adds the RV32M multiply/divide family as multi-cycle operations behind a valid/ready handshake.
- Sits in the execute stage. The hazard unit stalls issue while in_ready is low.

Parameters:
W, 32, datapath width in bits (even, >=8)
MUL_LAT, 2, multiply result latency in cycles after acceptance (1..4)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operation presented
in_ready  output  1  unit can accept this cycle
md_sel  input  1  0: base ALU op, 1: M-extension op
ALUctrl  input  4  base op code (md_sel=0); bits[2:0] = M funct3 (md_sel=1)
N1  input  W  operand 1 (rs1/PC)
N2  input  W  operand 2 (rs2/imm)
out_valid  output  1  result/flag valid
out_ready  input  1  consumer accepts result
out  output  W  result
flag  output  1  branch-taken / compare flag
busy  output  1  multi-cycle op in flight

Behaviour:
- Handshake and timing:
  - Accept when in_valid && in_ready. Operands and op are captured at acceptance; later input changes are ignored.
  - in_ready = (state==IDLE) && (!out_valid || out_ready), so accept and drain can happen in the same cycle.
  - out, flag and out_valid are registered. Once asserted, they hold stable until the cycle with out_valid && out_ready.
- Reset values: out_valid=0, out=0, flag=0, busy=0, state=IDLE. A reset asserted mid-operation discards the op, with no result emitted.
- States:
  - IDLE: base op accepted -> result next cycle, stay IDLE. MUL* accepted -> MUL. DIV*/REM* accepted -> DIV.
  - MUL: counts MUL_LAT-1 cycles, then drives out_valid and returns to IDLE. With MUL_LAT=1, behaves like a base op.
  - DIV: radix-2 restoring iteration, one quotient bit per cycle, W cycles, then one fix-up cycle (sign correction) -> out_valid -> IDLE. Latency is W+1 cycles after acceptance.
  - busy=1 in MUL and DIV.
- Special divide cases are resolved at acceptance and take latency 1:
  - divide by zero: quotient=all ones, remainder=N1.
  - signed overflow (N1=-2^(W-1), N2=-1): quotient=N1, remainder=0.
  - flag=1 for all M ops.
- Base ops (md_sel=0):
  - 0000 add: N1+N2, flag=1.
  - 0001: N2, flag=1.
  - 0010 and, 0011 or, 0100 xor: flag=1.
  - 0101 sll, 0110 srl, 0111 sra: shift amount is N2[log2(W)-1:0] only. Upper bits are ignored.
- Compare/sub ops: {C,diff} = N1 + ~N2 + 1 at W+1 bits. Z=(diff==0), S=diff[W-1], V=(N1[W-1]!=N2[W-1]) && (diff[W-1]!=N1[W-1]).
  - 1000: flag=Z.
  - 1001: flag=!Z.
  - 1010 sub: flag=0.
  - 1100: flag=S^V, out=zero-extended flag.
  - 1101: flag=!(S^V).
  - 1110: flag=!C, out=zero-extended flag.
  - 1111: flag=C.
  - 1011: out=diff, flag=1.
  - For all other 1xxx codes, out=diff.
- M ops: funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Product is formed at 2W bits from sign/zero-extended operands.
  - MUL returns the low W bits; the others return the high W bits.
  - DIV/REM truncate toward zero. Remainder sign = dividend sign.
- Back-to-back: one base op per cycle when out_ready is held 1.
- Simultaneous out_ready and a new acceptance: the old result drains and the new one loads in the same edge.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit base op constants (ALU_ADD … ALU_BGEU);
  - an M funct3 enum;
  - the state enum {IDLE, MUL, DIV};
  - the special-case result constants.
- Sub-module div_iter implements the iterative unsigned divider:
  - start/done;
  - W-cycle counter;
  - quotient/remainder registers.
  - alu_mdu handles sign conversion and special cases.
- The multiplier is an inferred product with a MUL_LAT-1 stage delay pipe, local to alu_mdu.

Test Plan:
- W=32, base add 5+7, then beq 3,3, held out_ready=1 -> out=12 at cycle+1, then flag=1 at cycle+2, with in_ready continuously 1.
- slt N1=0xFFFFFFFF, N2=1 -> out=1. sltu with the same operands -> out=0. bge 0x80000000 vs 1 -> flag=0.
- MUL_LAT=2: MULH 0x80000000 × 0x80000000 -> out_valid exactly 2 cycles after acceptance, out=0x40000000. MULHU 0xFFFFFFFF × 2 -> out=1.
- DIV -7/2 -> out=0xFFFFFFFD after 33 cycles, busy=1 throughout, in_ready=0. REM -7/2 -> 0xFFFFFFFF.
- DIVU x/0 -> out=0xFFFFFFFF after 1 cycle. DIV 0x80000000/-1 -> 0x80000000. REM same operands -> 0.
- Backpressure: out_ready=0 with DIV result pending -> out held stable 5 cycles, in_ready=0. Reset asserted at DIV cycle 10 -> next cycle out_valid=0, busy=0, in_ready=1.
